robot_nav_ctrl: RTL and testbench



---
 rtl/robot_nav_ctrl.sv | 131 +++++++++++++
 tb/tb_robot_nav_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/robot_nav_ctrl.sv
// robot_nav_ctrl: nearest-obstacle reduction over N distance channels driving a speed/steer FSM
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   enable          run request, low forces IDLE
//   dist_v          packed distances, channel i at [i*DIST_W +: DIST_W]
//   dist_vld        dist_v valid this cycle
//   speed           motor speed command
//   turn_en         steering active (TURN)
//   turn_dir        0 = left, 1 = right, holds last latched value
//   state           IDLE=0 FWD=1 SLOW=2 STOP=3 TURN=4 FAULT=5
//   fault           high in FAULT
module robot_nav_ctrl #(
    parameter int N_SENS    = 4,
    parameter int DIST_W    = 16,
    parameter int SLOW_TH   = 1000,
    parameter int STOP_TH   = 300,
    parameter int HYST      = 50,
    parameter int STOP_WAIT = 4,
    parameter int TURN_CYC  = 8,
    parameter int MAX_TURNS = 3,
    parameter int SPD_W     = 8,
    parameter int SPD_MAX   = 200,
    parameter int SPD_TURN  = 60
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [N_SENS*DIST_W-1:0] dist_v,
    input  logic                     dist_vld,
    output logic [SPD_W-1:0]         speed,
    output logic                     turn_en,
    output logic                     turn_dir,
    output logic [2:0]               state,
    output logic                     fault
);
    localparam int IW = $clog2(N_SENS);
    localparam int WW = $clog2(STOP_WAIT + 1);
    localparam int TW = $clog2(TURN_CYC + 1);
    localparam int CW = $clog2(MAX_TURNS + 1);
    localparam logic [DIST_W-1:0] STOP_T   = DIST_W'(STOP_TH);
    localparam logic [DIST_W-1:0] SLOW_T   = DIST_W'(SLOW_TH);
    // release thresholds carry one extra bit so TH+HYST cannot wrap
    localparam logic [DIST_W:0]   STOP_REL = (DIST_W+1)'(STOP_TH + HYST);
    localparam logic [DIST_W:0]   SLOW_REL = (DIST_W+1)'(SLOW_TH + HYST);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FWD   = 3'd1,
        S_SLOW  = 3'd2,
        S_STOP  = 3'd3,
        S_TURN  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    state_t            r_state, w_next;
    logic [DIST_W-1:0] r_min_d, w_min_d;
    logic [IW-1:0]     r_min_idx, w_min_idx;
    logic              r_min_vld;
    logic [WW-1:0]     r_wait_cnt;
    logic [TW-1:0]     r_turn_timer;
    logic [CW-1:0]     r_turn_cnt;
    logic              r_turn_dir;
    logic              w_enter_turn;

    // strict less-than keeps the lowest index on ties
    always_comb begin
        w_min_d   = dist_v[DIST_W-1:0];
        w_min_idx = '0;
        for (int i = 1; i < N_SENS; i++)
            if (dist_v[i*DIST_W +: DIST_W] < w_min_d) begin
                w_min_d   = dist_v[i*DIST_W +: DIST_W];
                w_min_idx = IW'(i);
            end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_min_d   <= '0;
            r_min_idx <= '0;
            r_min_vld <= 1'b0;
        end else begin
            r_min_vld <= dist_vld;
            if (dist_vld) begin
                r_min_d   <= w_min_d;
                r_min_idx <= w_min_idx;
            end
        end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = S_FWD;
            S_FWD:   if (r_min_vld) w_next = r_min_d < STOP_T ? S_STOP : r_min_d < SLOW_T ? S_SLOW : S_FWD;
            S_SLOW:  if (r_min_vld) w_next = r_min_d < STOP_T ? S_STOP : {1'b0, r_min_d} >= SLOW_REL ? S_FWD : S_SLOW;
            // a fresh release sample beats the wait timer in the same cycle
            S_STOP:  w_next = (r_min_vld && {1'b0, r_min_d} >= STOP_REL) ? S_SLOW :
                              r_wait_cnt == WW'(STOP_WAIT - 1) ? (r_turn_cnt == CW'(MAX_TURNS) ? S_FAULT : S_TURN) : S_STOP;
            S_TURN:  w_next = r_turn_timer == TW'(TURN_CYC - 1) ? S_STOP : S_TURN;
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_IDLE;
        endcase
        if (!enable) w_next = S_IDLE;
    end

    assign w_enter_turn = (w_next == S_TURN) && (r_state != S_TURN);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= '0;
            r_turn_timer <= '0;
            r_turn_cnt   <= '0;
            r_turn_dir   <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_wait_cnt   <= (r_state == S_STOP && w_next == S_STOP) ? r_wait_cnt + 1'b1 : '0;
            r_turn_timer <= (r_state == S_TURN && w_next == S_TURN) ? r_turn_timer + 1'b1 : '0;
            r_turn_cnt   <= (!enable || w_next == S_FWD) ? '0 :
                            (w_enter_turn && r_turn_cnt != CW'(MAX_TURNS)) ? r_turn_cnt + 1'b1 : r_turn_cnt;
            // obstacle in the lower half of the channels steers right
            r_turn_dir   <= w_enter_turn ? (r_min_idx < IW'(N_SENS / 2)) : r_turn_dir;
        end

    assign speed    = r_state == S_FWD  ? SPD_W'(SPD_MAX) :
                      r_state == S_SLOW ? SPD_W'(SPD_MAX >> 1) :
                      r_state == S_TURN ? SPD_W'(SPD_TURN) : '0;
    assign turn_en  = r_state == S_TURN;
    assign turn_dir = r_turn_dir;
    assign state    = r_state;
    assign fault    = r_state == S_FAULT;
endmodule

// File: tb/tb_robot_nav_ctrl.sv
// tb_robot_nav_ctrl: scoreboard bench for robot_nav_ctrl with a cycle model and directed spot checks
module tb_robot_nav_ctrl;
    localparam logic [15:0] FAR = 16'h7FFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [63:0] dist_v;
    logic        dist_vld = 1'b0;
    logic [7:0]  speed;
    logic        turn_en, turn_dir, fault;
    logic [2:0]  state;

    int n_chk = 0;
    int n_fail = 0;
    logic [13:0] sb[$];

    int m_state, m_wait, m_timer, m_tcnt, m_dir, m_d, m_idx, m_vld;

    robot_nav_ctrl dut (
        .clk(clk), .rst(rst), .enable(enable), .dist_v(dist_v), .dist_vld(dist_vld),
        .speed(speed), .turn_en(turn_en), .turn_dir(turn_dir), .state(state), .fault(fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [13:0] obs();
        return {state, speed, turn_en, turn_dir, fault};
    endfunction

    function automatic logic [13:0] model_out();
        int spd;
        spd = m_state == 1 ? 200 : m_state == 2 ? 100 : m_state == 4 ? 60 : 0;
        return {3'(m_state), 8'(spd), m_state == 4, m_dir[0], m_state == 5};
    endfunction

    task automatic model_reset();
        m_state = 0; m_wait = 0; m_timer = 0; m_tcnt = 0; m_dir = 0; m_d = 0; m_idx = 0; m_vld = 0;
    endtask

    task automatic model_step(input logic en, input logic vld, input logic [63:0] dv);
        int ns;
        ns = m_state;
        if (!en) ns = 0;
        else if (m_state == 0) ns = 1;
        else if (m_state == 1) begin
            if (m_vld != 0 && m_d < 300) ns = 3;
            else if (m_vld != 0 && m_d < 1000) ns = 2;
        end else if (m_state == 2) begin
            if (m_vld != 0 && m_d < 300) ns = 3;
            else if (m_vld != 0 && m_d >= 1050) ns = 1;
        end else if (m_state == 3) begin
            if (m_vld != 0 && m_d >= 350) ns = 2;
            else if (m_wait == 3) ns = (m_tcnt == 3) ? 5 : 4;
        end else if (m_state == 4) begin
            if (m_timer == 7) ns = 3;
        end
        m_wait  = (m_state == 3 && ns == 3) ? m_wait + 1 : 0;
        m_timer = (m_state == 4 && ns == 4) ? m_timer + 1 : 0;
        if (ns == 4 && m_state != 4) begin
            m_dir = (m_idx < 2) ? 1 : 0;
            if (m_tcnt < 3) m_tcnt++;
        end
        if (!en || ns == 1) m_tcnt = 0;
        m_state = ns;
        m_vld = vld ? 1 : 0;
        if (vld) begin
            m_d = int'(dv[15:0]);
            m_idx = 0;
            for (int i = 1; i < 4; i++)
                if (int'(dv[i*16 +: 16]) < m_d) begin
                    m_d = int'(dv[i*16 +: 16]);
                    m_idx = i;
                end
        end
    endtask

    task automatic tick(input logic en, input logic vld, input logic [63:0] dv);
        logic [13:0] e;
        enable = en;
        dist_vld = vld;
        dist_v = dv;
        model_step(en, vld, dv);
        sb.push_back(model_out());
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check("scoreboard", 32'(obs()), 32'(e));
    endtask

    task automatic sample(input logic [63:0] dv);
        tick(1'b1, 1'b1, dv);
        tick(1'b1, 1'b0, dv);
    endtask

    task automatic ticks(input int n, input logic [63:0] dv);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, dv);
    endtask

    initial begin
        logic [63:0] far4, dv;
        int nturn, prev;
        far4 = pack(FAR, FAR, FAR, FAR);
        dist_v = far4;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_state", 32'(state), 0);
        check("rst_speed", 32'(speed), 0);
        check("rst_turn_en", 32'(turn_en), 0);
        check("rst_fault", 32'(fault), 0);
        rst = 1'b0;

        tick(1'b1, 1'b1, far4);
        check("fwd_state", 32'(state), 1);
        check("fwd_speed", 32'(speed), 200);
        ticks(2, far4);

        sample(pack(900, FAR, FAR, FAR));
        check("slow_state", 32'(state), 2);
        check("slow_speed", 32'(speed), 100);
        sample(pack(1020, FAR, FAR, FAR));
        check("slow_hold_1020", 32'(state), 2);
        sample(pack(1049, FAR, FAR, FAR));
        check("slow_hold_1049", 32'(state), 2);
        sample(pack(1050, FAR, FAR, FAR));
        check("fwd_at_1050", 32'(state), 1);
        check("fwd_speed_1050", 32'(speed), 200);

        sample(pack(FAR, 250, FAR, FAR));
        check("stop_state", 32'(state), 3);
        check("stop_speed", 32'(speed), 0);
        ticks(3, far4);
        check("stop_before_turn", 32'(state), 3);
        ticks(1, far4);
        check("turn_state", 32'(state), 4);
        check("turn_dir_ch1", 32'(turn_dir), 1);
        check("turn_speed", 32'(speed), 60);
        for (int i = 1; i < 8; i++) begin
            tick(1'b1, 1'b0, far4);
            check("turn_en_held", 32'(turn_en), 1);
        end
        tick(1'b1, 1'b0, far4);
        check("turn_to_stop", 32'(state), 3);
        sample(far4);
        check("stop_release", 32'(state), 2);
        sample(far4);
        check("back_fwd", 32'(state), 1);

        sample(pack(100, FAR, 100, FAR));
        ticks(4, far4);
        check("tie_turn", 32'(state), 4);
        check("tie_dir", 32'(turn_dir), 1);
        ticks(8, far4);
        sample(far4);
        sample(far4);
        check("tie_back_fwd", 32'(state), 1);

        sample(pack(FAR, FAR, FAR, 100));
        ticks(4, far4);
        check("ch3_turn", 32'(state), 4);
        check("ch3_dir", 32'(turn_dir), 0);
        ticks(8, far4);
        sample(far4);
        sample(far4);
        check("ch3_back_fwd", 32'(state), 1);

        dv = pack(100, FAR, FAR, FAR);
        nturn = 0;
        prev = 1;
        for (int i = 0; i < 200 && state != 3'd5; i++) begin
            tick(1'b1, 1'b1, dv);
            if (state == 3'd4 && prev != 4) nturn++;
            prev = int'(state);
        end
        check("fault_reached", 32'(state), 5);
        check("fault_turns", 32'(nturn), 3);
        check("fault_flag", 32'(fault), 1);
        check("fault_speed", 32'(speed), 0);
        tick(1'b0, 1'b0, dv);
        check("idle_after_disable", 32'(state), 0);
        tick(1'b1, 1'b1, far4);
        check("refwd", 32'(state), 1);
        sample(pack(100, FAR, FAR, FAR));
        ticks(4, far4);
        check("turn_cnt_cleared", 32'(state), 4);
        ticks(2, far4);

        #2;
        rst = 1'b1;
        #1;
        check("async_state", 32'(state), 0);
        check("async_speed", 32'(speed), 0);
        check("async_turn_en", 32'(turn_en), 0);
        check("async_turn_dir", 32'(turn_dir), 0);
        check("async_fault", 32'(fault), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < 400; i++) begin
            dv = pack($urandom_range(0, 1200), $urandom_range(0, 1200),
                      $urandom_range(0, 1200), $urandom_range(0, 1200));
            tick($urandom_range(0, 19) != 0, $urandom_range(0, 2) == 0, dv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
